// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter for a 16-bit Avalon-MM SDRAM master port with read-ID tracking.
// Define SDRAM_ARB_PRIO0_EN for fixed priority to requester 0; round-robin otherwise.
module sdram_port_arbiter #(
  parameter int unsigned MAX_PEND = 4,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            c_valid,
  input  logic [1:0]            c_write,
  input  logic [2*ADDR_W-1:0]   c_addr,
  input  logic [31:0]           c_wdata,
  output logic [1:0]            c_ready,
  output logic [1:0]            r_valid,
  output logic [15:0]           r_data,
  input  logic                  waitrequest,
  input  logic                  readdatavalid,
  input  logic [15:0]           readdata,
  output logic                  chipselect,
  output logic [1:0]            byteenable,
  output logic                  read_n,
  output logic                  write_n,
  output logic [ADDR_W-1:0]     address,
  output logic [15:0]           writedata,
  output logic                  busy,
  output logic                  rd_err
);

  localparam int unsigned PtrW = $clog2(MAX_PEND);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                read_n_q, read_n_d;
  logic                write_n_q, write_n_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [15:0]         writedata_q, writedata_d;
  logic                rd_err_q, rd_err_d;

  logic [MAX_PEND-1:0] fifo_mem_q;
  logic [PtrW:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       fifo_count;
  logic                fifo_empty, fifo_full;
  logic                push, pop, head;

  logic [1:0]          eligible;
  logic                pick;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_count == '0);
  // Count never exceeds MAX_PEND (a power of 2), so its MSB alone flags full.
  assign fifo_full  = fifo_count[PtrW];
  assign head       = fifo_mem_q[rd_ptr_q[PtrW-1:0]];

  assign eligible[0] = c_valid[0] & (c_write[0] | ~fifo_full);
  assign eligible[1] = c_valid[1] & (c_write[1] | ~fifo_full);

  always_comb begin
    pick = 1'b0;
`ifdef SDRAM_ARB_PRIO0_EN
    pick = ~eligible[0];
`else
    if (eligible[1]) begin
      pick = eligible[0] ? ~last_grant_q : 1'b1;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    read_n_d     = read_n_q;
    write_n_d    = write_n_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    c_ready      = 2'b00;
    push         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|eligible) begin
          grant_d      = pick;
          last_grant_d = pick;
          address_d    = pick ? c_addr[2*ADDR_W-1:ADDR_W] : c_addr[ADDR_W-1:0];
          writedata_d  = pick ? c_wdata[31:16] : c_wdata[15:0];
          read_n_d     = c_write[pick];
          write_n_d    = ~c_write[pick];
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (!waitrequest) begin
          c_ready[grant_q] = 1'b1;
          push             = ~read_n_q;
          read_n_d         = 1'b1;
          write_n_d        = 1'b1;
          state_d          = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop      = readdatavalid & ~fifo_empty;
  assign rd_err_d = rd_err_q | (readdatavalid & fifo_empty);

  always_comb begin
    r_valid = 2'b00;
    if (pop) begin
      r_valid = head ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      read_n_q     <= 1'b1;
      write_n_q    <= 1'b1;
      address_q    <= '0;
      writedata_q  <= '0;
      rd_err_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      read_n_q     <= read_n_d;
      write_n_q    <= write_n_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      rd_err_q     <= rd_err_d;
      wr_ptr_q     <= wr_ptr_q + {{PtrW{1'b0}}, push};
      rd_ptr_q     <= rd_ptr_q + {{PtrW{1'b0}}, pop};
    end
  end

  // Storage needs no reset: pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q[PtrW-1:0]] <= grant_q;
    end
  end

  assign r_data     = readdata;
  assign chipselect = 1'b1;
  assign byteenable = 2'b11;
  assign read_n     = read_n_q;
  assign write_n    = write_n_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign rd_err     = rd_err_q;
  assign busy       = (state_q != StIdle) | ~fifo_empty;

endmodule
